// File: rtl/alu_pkg.sv
// Shared opcode/state types for the sequential N-bit ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_LSR = 4'd5,
    OP_LSL = 4'd6,
    OP_MOD = 4'd7,
    OP_MUL = 4'd8,
    OP_DIV = 4'd9
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } alu_state_e;

  localparam logic [3:0] ALU_OP_LAST = 4'd9;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative restoring divider / shift-add multiplier sharing one hi/lo register pair.
// Multiply datapath exists only when ALU_MUL_EN is defined.
module alu_iter_unit #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         is_mul,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         finish,
  output logic [N-1:0] hi_nxt,
  output logic [N-1:0] lo_nxt
);
  localparam int CW = $clog2(N);

  logic [N-1:0]  hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mul_q, mul_d;

  logic [N-1:0] src_hi, src_lo, src_b;
  logic         src_mul;
  logic [N:0]   r_sh;
  logic [N-1:0] diff;
  logic         ge;
  logic [N-1:0] hi_div, lo_div;

  // The load edge already performs the first step, so the last step is
  // taken combinationally on the edge where cnt reaches zero.
  always_comb begin
    src_hi  = load ? '0 : hi_q;
    src_lo  = load ? a : lo_q;
    src_b   = load ? b : b_q;
    src_mul = load ? is_mul : mul_q;

    r_sh   = {src_hi, src_lo[N-1]};
    ge     = (r_sh >= {1'b0, src_b});
    diff   = r_sh[N-1:0] - src_b;
    hi_div = ge ? diff : r_sh[N-1:0];
    lo_div = {src_lo[N-2:0], ge};
  end

`ifdef ALU_MUL_EN
  logic [N:0] mul_sum;

  always_comb begin
    mul_sum = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_b} : '0);
    hi_nxt  = src_mul ? mul_sum[N:1] : hi_div;
    lo_nxt  = src_mul ? {mul_sum[0], src_lo[N-1:1]} : lo_div;
  end
`else
  logic unused_src_mul;
  assign unused_src_mul = src_mul;
  assign hi_nxt = hi_div;
  assign lo_nxt = lo_div;
`endif

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    b_d    = b_q;
    mul_d  = mul_q;
    cnt_d  = cnt_q;
    finish = 1'b0;
    if (load) begin
      hi_d  = hi_nxt;
      lo_d  = lo_nxt;
      b_d   = b;
      mul_d = is_mul;
      cnt_d = CW'(N - 1);
    end else if (cnt_q != '0) begin
      hi_d   = hi_nxt;
      lo_d   = lo_nxt;
      cnt_d  = cnt_q - 1'b1;
      finish = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      mul_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      mul_q <= mul_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq_n_bits.sv
// Clocked N-bit ALU with start/done handshake; ALU_MUL_EN enables iterative multiply.
// state | meaning
// IDLE  | waiting for start; single-cycle ops complete here
// ITER  | div/mod/mul stepping in alu_iter_unit
module alu_seq_n_bits
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         v,
  output logic         c,
  output logic         n,
  output logic         z,
  output logic         dz
);
  alu_state_e   state_q, state_d;
  logic [3:0]   op_q, op_d;
  logic [N-1:0] res_q, res_d;
  logic         v_q, v_d, c_q, c_d, n_q, n_d, z_q, z_d, dz_q, dz_d, done_q, done_d;

  logic         load, is_mul, finish;
  logic [N-1:0] hi_nxt, lo_nxt;

  logic         sub, sc_v, sc_c, sc_dz, iter_req;
  logic [N-1:0] bx, sc_res, it_res;
  logic [N:0]   sum;

`ifdef ALU_MUL_EN
  assign is_mul = (op == OP_MUL);
`else
  assign is_mul = 1'b0;
`endif

  alu_iter_unit #(.N(N)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .is_mul (is_mul),
    .a      (a),
    .b      (b),
    .finish (finish),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  always_comb begin
    sub      = (op == OP_SUB);
    bx       = b ^ {N{sub}};
    sum      = {1'b0, a} + {1'b0, bx} + {{N{1'b0}}, sub};
    sc_res   = '0;
    sc_v     = 1'b0;
    sc_c     = 1'b0;
    sc_dz    = 1'b0;
    iter_req = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        sc_res = sum[N-1:0];
        sc_c   = sum[N];
        sc_v   = (a[N-1] == bx[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_XOR: sc_res = a ^ b;
      OP_LSR: sc_res = a >> b;
      OP_LSL: sc_res = a << b;
      // Non-zero divisor goes iterative; these are the b==0 results.
      OP_MOD: begin
        sc_res   = a;
        sc_dz    = (b == '0);
        iter_req = (b != '0);
      end
      OP_DIV: begin
        sc_res   = '1;
        sc_dz    = (b == '0);
        iter_req = (b != '0);
      end
`ifdef ALU_MUL_EN
      OP_MUL: iter_req = (b != '0);
`else
      OP_MUL: sc_res = a;
`endif
      default: sc_dz = (op > ALU_OP_LAST);
    endcase
  end

  assign it_res = (op_q == OP_MOD) ? hi_nxt : lo_nxt;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    v_d     = v_q;
    c_d     = c_q;
    n_d     = n_q;
    z_d     = z_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d = op;
          if (iter_req) begin
            load    = 1'b1;
            state_d = ITER;
          end else begin
            res_d  = sc_res;
            v_d    = sc_v;
            c_d    = sc_c;
            dz_d   = sc_dz;
            n_d    = sc_res[N-1];
            z_d    = (sc_res == '0);
            done_d = 1'b1;
          end
        end
      end
      ITER: begin
        if (finish) begin
          res_d   = it_res;
          v_d     = (op_q == OP_MUL) && (hi_nxt != '0);
          c_d     = (op_q == OP_MUL) && (hi_nxt != '0);
          dz_d    = 1'b0;
          n_d     = it_res[N-1];
          z_d     = (it_res == '0);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      res_q   <= '0;
      v_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      v_q     <= v_d;
      c_q     <= c_d;
      n_q     <= n_d;
      z_q     <= z_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign busy   = (state_q == ITER);
  assign done   = done_q;
  assign result = res_q;
  assign v      = v_q;
  assign c      = c_q;
  assign n      = n_q;
  assign z      = z_q;
  assign dz     = dz_q;

endmodule

// File: tb/tb_alu_seq_n_bits.sv
// Directed bench for alu_seq_n_bits at N=4; flags compared as {v,c,n,z,dz}.
module tb_alu_seq_n_bits;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op_i = '0;
  logic [N-1:0] a_i = '0;
  logic [N-1:0] b_i = '0;
  logic         busy, done, v, c, n, z, dz;
  logic [N-1:0] result;

  int checks = 0;
  int errors = 0;
  int dn_cnt;

  alu_seq_n_bits #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op_i),
    .a      (a_i),
    .b      (b_i),
    .busy   (busy),
    .done   (done),
    .result (result),
    .v      (v),
    .c      (c),
    .n      (n),
    .z      (z),
    .dz     (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {27'd0, v, c, n, z, dz};
  endfunction

  // Call at a negedge; returns at the negedge of the done cycle (or after the bound).
  task automatic issue(input logic [3:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                       output int lat, output int bcnt);
    op_i  = o;
    a_i   = x;
    b_i   = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    bcnt  = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input logic [3:0] o, input logic [N-1:0] x,
                          input logic [N-1:0] y, input int exp_lat, input int exp_busy,
                          input logic [N-1:0] exp_res, input logic [4:0] exp_flags);
    int lat, bcnt;
    issue(o, x, y, lat, bcnt);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busycycles"}, bcnt, exp_busy);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 0);
    chk({tag, "_result"}, {28'd0, result}, {28'd0, exp_res});
    chk({tag, "_flags"}, flags(), {27'd0, exp_flags});
  endtask

  initial begin
    @(negedge clk);
    chk("reset_result", {28'd0, result}, 0);
    chk("reset_flags", flags(), 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    @(negedge clk);

    check_op("sub_eq", 4'd1, 4'd5, 4'd5, 1, 0, 4'd0,  5'b01010);
    check_op("add",    4'd0, 4'd7, 4'd1, 1, 0, 4'd8,  5'b10100);
    check_op("sub",    4'd1, 4'd3, 4'd5, 1, 0, 4'd14, 5'b00100);

    // Reset two cycles into a division: outputs clear, no done afterwards.
    op_i = 4'd9; a_i = 4'd13; b_i = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_busy", {31'd0, busy}, 0);
    chk("rstmid_done", {31'd0, done}, 0);
    chk("rstmid_result", {28'd0, result}, 0);
    chk("rstmid_flags", flags(), 0);
    @(negedge clk);
    rst = 1'b0;
    dn_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) dn_cnt++;
    end
    chk("rstmid_no_done", dn_cnt, 0);

    check_op("div",  4'd9, 4'd13, 4'd4, 4, 3, 4'd3,  5'b00000);
    check_op("mod",  4'd7, 4'd13, 4'd4, 4, 3, 4'd1,  5'b00000);
    check_op("divz", 4'd9, 4'd13, 4'd0, 1, 0, 4'd15, 5'b00101);
    check_op("modz", 4'd7, 4'd6,  4'd0, 1, 0, 4'd6,  5'b00001);
`ifdef ALU_MUL_EN
    check_op("mul",  4'd8, 4'd7,  4'd5, 4, 3, 4'd3,  5'b11000);
`else
    check_op("mul",  4'd8, 4'd7,  4'd5, 1, 0, 4'd7,  5'b00000);
`endif
    check_op("lsr_big", 4'd5, 4'd15, 4'd4, 1, 0, 4'd0, 5'b00010);
    check_op("illegal", 4'd12, 4'd5, 4'd3, 1, 0, 4'd0, 5'b00011);

    // Start pulsed mid-division is ignored; start in the done cycle is taken.
    op_i = 4'd9; a_i = 4'd13; b_i = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hs_busy1", {31'd0, busy}, 1);
    op_i = 4'd0; a_i = 4'd1; b_i = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hs_ignored_done", {31'd0, done}, 0);
    chk("hs_busy2", {31'd0, busy}, 1);
    @(negedge clk);
    @(negedge clk);
    chk("hs_div_done", {31'd0, done}, 1);
    chk("hs_div_result", {28'd0, result}, 3);
    op_i = 4'd6; a_i = 4'd3; b_i = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hs_b2b_done", {31'd0, done}, 1);
    chk("hs_b2b_result", {28'd0, result}, 12);
    chk("hs_b2b_flags", flags(), 5'b00100);
    @(negedge clk);
    chk("hs_done_pulse", {31'd0, done}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
